punc_control: RTL

Multi-cycle instruction sequencer for the PUnC LC3 processor. It sits directly upstream of the PUnC datapath. Each cycle it decodes the datapath's `ir` and condition flags and drives every datapath control input, so the datapath fetches, decodes and executes one LC3 instruction at a time. It also owns the HALT state.

---
 rtl/punc_control_if.sv | 61 ++++++
 rtl/punc_control.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/punc_control_if.sv
// rtl/punc_control_if.sv - PUnC controller/datapath control bundle
//
// Groups every signal exchanged between punc_control and the PUnC datapath.
//   master : the controller (reads ir and flags, drives every control)
//   slave  : the datapath  (drives ir and flags, consumes every control)
// Signals:
//   ir[15:0]         instruction register contents
//   N, Z, P          condition flags
//   MUX_input[1:0]   memory read address: 00 pc, 10 EA, 11 Mem_store
//   PCMUX[1:0]       00 pc<=EA, 01 pc<=pc+1, 11 hold
//   pcld, pcclr      pc load (unused, 0) / pc clear
//   MUX[1:0]         register write data: 00 ALU, 01 memory, 10 pc
//   MUX_w_addr       memory write address: 0 EA, 1 Mem_store
//   mem_en, irld     memory write enable / IR load
//   reg_w_addr[2:0]  register write address, reg_w_en its enable
//   regIn1, regIn2   register read addresses
//   regIn3[15:0]     sign-extended immediate
//   reg_chk1/2       ALU operand selects
//   ALU_Cur[3:0]     0001 add, 0010 and, 0100 pass A, 1000 not A
//   cond_chk/cond_en flag source select / flag update
//   halted, state_dbg[2:0]  status
interface punc_control_if;
    logic [15:0] ir;
    logic        N;
    logic        Z;
    logic        P;
    logic [1:0]  MUX_input;
    logic [1:0]  PCMUX;
    logic        pcld;
    logic        pcclr;
    logic [1:0]  MUX;
    logic        MUX_w_addr;
    logic        mem_en;
    logic        irld;
    logic [2:0]  reg_w_addr;
    logic        reg_w_en;
    logic [2:0]  regIn1;
    logic [2:0]  regIn2;
    logic [15:0] regIn3;
    logic        reg_chk1;
    logic        reg_chk2;
    logic [3:0]  ALU_Cur;
    logic        cond_chk;
    logic        cond_en;
    logic        halted;
    logic [2:0]  state_dbg;

    modport master (
        input  ir, N, Z, P,
        output MUX_input, PCMUX, pcld, pcclr, MUX, MUX_w_addr, mem_en, irld,
               reg_w_addr, reg_w_en, regIn1, regIn2, regIn3, reg_chk1,
               reg_chk2, ALU_Cur, cond_chk, cond_en, halted, state_dbg
    );

    modport slave (
        output ir, N, Z, P,
        input  MUX_input, PCMUX, pcld, pcclr, MUX, MUX_w_addr, mem_en, irld,
               reg_w_addr, reg_w_en, regIn1, regIn2, regIn3, reg_chk1,
               reg_chk2, ALU_Cur, cond_chk, cond_en, halted, state_dbg
    );
endinterface

// File: rtl/punc_control.sv
// rtl/punc_control.sv - PUnC LC3 multi-cycle instruction sequencer
//
// Steps the datapath through FETCH, DECODE, EXEC (and MEM1 for LDI/STI)
// for one instruction at a time, and parks in HALT on the halt opcode.
// The state register is the only flop; every control output is decoded
// combinationally from state, ir and the N/Z/P flags.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset (forces FETCH, asserts pcclr)
//   bus  punc_control_if.master - ir/flags in, all datapath controls out
// Parameter:
//   HALT_OPCODE  opcode that enters HALT (TRAP by default)
module punc_control #(
    parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
    input  logic clk,
    input  logic rst,
    punc_control_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM1   = 3'b011,
        S_HALT   = 3'b100
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_PASS = 4'b0100;
    localparam logic [3:0] ALU_NOT  = 4'b1000;

    state_t      state;
    logic [3:0]  opcode;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [15:0] imm5;
    logic [15:0] off6;
    logic [15:0] off9;
    logic [15:0] off11;
    logic        br_taken;

    assign opcode = bus.ir[15:12];
    assign dr     = bus.ir[11:9];
    assign sr1    = bus.ir[8:6];
    assign imm5   = {{11{bus.ir[4]}},  bus.ir[4:0]};
    assign off6   = {{10{bus.ir[5]}},  bus.ir[5:0]};
    assign off9   = {{7{bus.ir[8]}},   bus.ir[8:0]};
    assign off11  = {{5{bus.ir[10]}},  bus.ir[10:0]};
    assign br_taken = (bus.ir[11] & bus.N) | (bus.ir[10] & bus.Z) | (bus.ir[9] & bus.P);

    assign bus.state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: state <= (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
                S_EXEC:   state <= (opcode == OP_LDI || opcode == OP_STI) ? S_MEM1 : S_FETCH;
                S_MEM1:   state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.MUX_input  = 2'b00;
        bus.PCMUX      = 2'b11;
        bus.pcld       = 1'b0;
        bus.pcclr      = 1'b0;
        bus.MUX        = 2'b00;
        bus.MUX_w_addr = 1'b0;
        bus.mem_en     = 1'b0;
        bus.irld       = 1'b0;
        bus.reg_w_addr = 3'd0;
        bus.reg_w_en   = 1'b0;
        bus.regIn1     = 3'd0;
        bus.regIn2     = 3'd0;
        bus.regIn3     = 16'h0000;
        bus.reg_chk1   = 1'b0;
        bus.reg_chk2   = 1'b0;
        bus.ALU_Cur    = ALU_PASS;
        bus.cond_chk   = 1'b0;
        bus.cond_en    = 1'b0;
        bus.halted     = 1'b0;

        if (!rst) begin
            // Outputs are gated in reset so an aborted instruction can't write.
            bus.pcclr = 1'b1;
        end else begin
            case (state)
                S_FETCH: begin
                    bus.MUX_input = 2'b00;
                    bus.irld      = 1'b1;
                    bus.PCMUX     = 2'b01;
                end

                // EA is formed here and latched by the datapath into PCoffsetSum.
                S_DECODE: begin
                    bus.reg_chk1 = 1'b0;
                    bus.reg_chk2 = 1'b0;
                    bus.ALU_Cur  = ALU_ADD;
                    bus.regIn3   = off9;
                    case (opcode)
                        OP_JSR: begin
                            if (bus.ir[11]) begin
                                bus.regIn3 = off11;
                            end else begin
                                bus.reg_chk1 = 1'b1;
                                bus.regIn1   = sr1;
                                bus.ALU_Cur  = ALU_PASS;
                            end
                        end
                        OP_LDR, OP_STR: begin
                            bus.reg_chk1 = 1'b1;
                            bus.regIn1   = sr1;
                            bus.regIn3   = off6;
                        end
                        OP_JMP: begin
                            bus.reg_chk1 = 1'b1;
                            bus.regIn1   = sr1;
                            bus.ALU_Cur  = ALU_PASS;
                        end
                        default: ;
                    endcase
                end

                S_EXEC: begin
                    case (opcode)
                        OP_ADD, OP_AND, OP_NOT: begin
                            bus.regIn1   = sr1;
                            bus.reg_chk1 = 1'b1;
                            if (bus.ir[5]) begin
                                bus.reg_chk2 = 1'b0;
                                bus.regIn3   = imm5;
                            end else begin
                                bus.reg_chk2 = 1'b1;
                                bus.regIn2   = bus.ir[2:0];
                            end
                            bus.ALU_Cur    = (opcode == OP_ADD) ? ALU_ADD :
                                             (opcode == OP_AND) ? ALU_AND : ALU_NOT;
                            bus.MUX        = 2'b00;
                            bus.reg_w_addr = dr;
                            bus.reg_w_en   = 1'b1;
                            bus.cond_chk   = 1'b1;
                            bus.cond_en    = 1'b1;
                        end
                        OP_BR: begin
                            bus.PCMUX = br_taken ? 2'b00 : 2'b11;
                        end
                        OP_JMP: begin
                            bus.PCMUX = 2'b00;
                        end
                        // pc still holds the return address until this edge.
                        OP_JSR: begin
                            bus.MUX        = 2'b10;
                            bus.reg_w_addr = 3'd7;
                            bus.reg_w_en   = 1'b1;
                            bus.PCMUX      = 2'b00;
                        end
                        OP_LEA: begin
                            bus.reg_chk1   = 1'b0;
                            bus.reg_chk2   = 1'b0;
                            bus.ALU_Cur    = ALU_ADD;
                            bus.regIn3     = off9;
                            bus.MUX        = 2'b00;
                            bus.reg_w_addr = dr;
                            bus.reg_w_en   = 1'b1;
                            bus.cond_chk   = 1'b1;
                            bus.cond_en    = 1'b1;
                        end
                        OP_LD, OP_LDR: begin
                            bus.MUX_input  = 2'b10;
                            bus.MUX        = 2'b01;
                            bus.reg_w_addr = dr;
                            bus.reg_w_en   = 1'b1;
                            bus.cond_chk   = 1'b0;
                            bus.cond_en    = 1'b1;
                        end
                        OP_ST, OP_STR: begin
                            bus.MUX_w_addr = 1'b0;
                            bus.reg_chk2   = 1'b1;
                            bus.regIn2     = dr;
                            bus.mem_en     = 1'b1;
                        end
                        // Pointer fetch: Mem_store captures mem[EA] for MEM1.
                        OP_LDI, OP_STI: begin
                            bus.MUX_input = 2'b10;
                        end
                        default: ;
                    endcase
                end

                S_MEM1: begin
                    if (opcode == OP_LDI) begin
                        bus.MUX_input  = 2'b11;
                        bus.MUX        = 2'b01;
                        bus.reg_w_addr = dr;
                        bus.reg_w_en   = 1'b1;
                        bus.cond_chk   = 1'b0;
                        bus.cond_en    = 1'b1;
                    end else if (opcode == OP_STI) begin
                        bus.MUX_w_addr = 1'b1;
                        bus.reg_chk2   = 1'b1;
                        bus.regIn2     = dr;
                        bus.mem_en     = 1'b1;
                    end
                end

                S_HALT: begin
                    bus.halted = 1'b1;
                end

                default: ;
            endcase
        end
    end

endmodule
